// File: rtl/fpp_pkg.sv
// Shared types and constants for the fpp issue queue: function codes, NOP opcode,
// issue FSM state encoding and the queued entry layout.
package fpp_pkg;

    localparam logic [3:0] FN_NOP   = 4'h0;
    localparam logic [3:0] FN_LOAD  = 4'hE;
    localparam logic [3:0] FN_STORE = 4'hF;

    localparam logic [7:0] NOP_OP = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } fsm_state_e;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] data;
    } entry_t;

    function automatic logic is_load(input entry_t e);
        return (e.opcode[7:4] == FN_LOAD);
    endfunction

endpackage

// File: rtl/fpp_issue_fifo.sv
// Synchronous DEPTH-entry FIFO of issue entries; head is readable combinationally.
module fpp_issue_fifo
    import fpp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   wdata,
    input  logic                     pop,
    output entry_t                   rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fpp_issue_fifo: DEPTH must be a power of two, at least 2");
    end

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; overflow/underflow requests are dropped.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fpp_issue_queue.sv
// Issue stage for the 16-bit FP processor: queues host entries, presents opcodes, drives
// load data on DataBus and captures readback. Watchdog enabled by FPP_ISSUE_TIMEOUT_EN.
module fpp_issue_queue
    import fpp_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_HOLD = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_opcode,
    input  logic [15:0] in_data,
    output logic [7:0]  opcode,
    inout  wire  [15:0] DataBus,
    input  logic        flag,
    input  logic        fpp_done,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        timeout_err
);

    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("fpp_issue_queue: MAX_HOLD must be at least 2");
    end

    fsm_state_e              state_q, state_d;
    entry_t                  cur_q, cur_d;
    logic [7:0]              opcode_q, opcode_d;
    logic [15:0]             rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    entry_t                  fifo_head;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    wd_fire;
    logic                    drive_s;

    assign fifo_push = in_valid && in_ready;
    assign in_ready  = !fifo_full;

    fpp_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ('{opcode: in_opcode, data: in_data}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef FPP_ISSUE_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;

    // Hold counter runs only in WAIT, so ISSUE (and every other state) restarts it at zero.
    always_comb begin
        wd_fire = (state_q == WAIT) && !fpp_done && (hold_q == HOLD_LAST);
        if (state_q == WAIT) begin
            hold_d = hold_q + HW'(1);
        end else begin
            hold_d = '0;
        end
        timeout_d = timeout_q | wd_fire;
    end

    // Watchdog registers; the error is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            opcode_q   <= NOP_OP;
            rd_data_q  <= 16'h0000;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            opcode_q   <= opcode_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Next-state logic; IDLE and GAP pop the head whenever the FIFO has one.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_d    = fifo_head;
                    state_d  = ISSUE;
                end else begin
                    state_d  = IDLE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (fpp_done || wd_fire) begin
                    state_d = GAP;
                end else begin
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: opcode follows the entering state; bus drive is gated by flag combinationally.
    always_comb begin
        if ((state_d == ISSUE) || (state_d == WAIT)) begin
            opcode_d = cur_d.opcode;
        end else begin
            opcode_d = NOP_OP;
        end
        if (flag) begin
            rd_data_d = DataBus;
        end else begin
            rd_data_d = rd_data_q;
        end
        rd_valid_d = flag;
        drive_s    = is_load(cur_q) && ((state_q == ISSUE) || (state_q == WAIT)) && !flag;
    end

    assign DataBus  = drive_s ? cur_q.data : 16'hzzzz;
    assign opcode   = opcode_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_fpp_issue_queue.sv
// Directed self-checking bench for fpp_issue_queue (watchdog checks follow FPP_ISSUE_TIMEOUT_EN).
module tb_fpp_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_opcode;
    logic [15:0] in_data;
    logic [7:0]  opcode;
    wire  [15:0] DataBus;
    logic        flag;
    logic        fpp_done;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        timeout_err;

    logic        tb_drive;
    logic [15:0] tb_bus;

    int checks   = 0;
    int failures = 0;

    assign DataBus = tb_drive ? tb_bus : 16'hzzzz;

    always #5 clk = ~clk;

    fpp_issue_queue #(.DEPTH(4), .MAX_HOLD(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_data     (in_data),
        .opcode      (opcode),
        .DataBus     (DataBus),
        .flag        (flag),
        .fpp_done    (fpp_done),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Undriven bus reads as Z in 4-state simulators and 0 in 2-state ones.
    function automatic logic bus_released();
        return (DataBus === 16'hzzzz) || (DataBus === 16'h0000);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_one(input logic [7:0] op, input logic [15:0] d);
        in_valid  = 1'b1;
        in_opcode = op;
        in_data   = d;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic done_pulse();
        fpp_done = 1'b1;
        tick();
        fpp_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (opcode !== 8'h00) begin failures++; $display("FAIL reset_opcode got=%h exp=%h", opcode, 8'h00); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (!bus_released()) begin failures++; $display("FAIL reset_bus got=%h exp=released", DataBus); end
        checks++; if ({rd_valid, rd_data} !== 17'h0) begin failures++; $display("FAIL reset_rd got=%b/%h exp=0/0000", rd_valid, rd_data); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout_err); end
    endtask

    task automatic test_single_alu();
        push_one(8'h16, 16'h0000);
        checks++; if (opcode !== 8'h00 || busy !== 1'b1) begin failures++; $display("FAIL alu_queued opcode=%h busy=%b exp=00/1", opcode, busy); end
        tick();
        checks++; if (opcode !== 8'h16) begin failures++; $display("FAIL alu_issue got=%h exp=16", opcode); end
        done_pulse();
        checks++; if (opcode !== 8'h16) begin failures++; $display("FAIL alu_done_in_issue_ignored got=%h exp=16", opcode); end
        repeat (4) tick();
        checks++; if (opcode !== 8'h16) begin failures++; $display("FAIL alu_hold got=%h exp=16", opcode); end
        done_pulse();
        checks++; if (opcode !== 8'h00 || busy !== 1'b1) begin failures++; $display("FAIL alu_gap opcode=%h busy=%b exp=00/1", opcode, busy); end
        tick();
        checks++; if (opcode !== 8'h00 || busy !== 1'b0) begin failures++; $display("FAIL alu_idle opcode=%h busy=%b exp=00/0", opcode, busy); end
    endtask

    task automatic test_load_readback();
        push_one(8'hE3, 16'h3C00);
        tick();
        checks++; if (opcode !== 8'hE3 || DataBus !== 16'h3C00) begin failures++; $display("FAIL load_issue opcode=%h bus=%h exp=E3/3C00", opcode, DataBus); end
        tick();
        checks++; if (DataBus !== 16'h3C00) begin failures++; $display("FAIL load_wait_bus got=%h exp=3C00", DataBus); end
        flag     = 1'b1;
        tb_drive = 1'b1;
        tb_bus   = 16'h4248;
        #1;
        checks++; if (DataBus !== 16'h4248) begin failures++; $display("FAIL load_flag_release got=%h exp=4248", DataBus); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rb_early got=%b exp=0", rd_valid); end
        tick();
        flag     = 1'b0;
        tb_drive = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h4248) begin failures++; $display("FAIL rb_capture valid=%b data=%h exp=1/4248", rd_valid, rd_data); end
        #1;
        checks++; if (DataBus !== 16'h3C00) begin failures++; $display("FAIL load_redrive got=%h exp=3C00", DataBus); end
        tick();
        checks++; if (rd_valid !== 1'b0 || rd_data !== 16'h4248) begin failures++; $display("FAIL rb_pulse valid=%b data=%h exp=0/4248", rd_valid, rd_data); end
        done_pulse();
        checks++; if (!bus_released() || DataBus === 16'h3C00) begin failures++; $display("FAIL load_gap_bus got=%h exp=released", DataBus); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL load_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_readback_idle();
        flag     = 1'b1;
        tb_drive = 1'b1;
        tb_bus   = 16'hA5F0;
        tick();
        flag     = 1'b0;
        tb_drive = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 16'hA5F0) begin failures++; $display("FAIL rb_idle valid=%b data=%h exp=1/A5F0", rd_valid, rd_data); end
        tick();
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rb_idle_pulse got=%b exp=0", rd_valid); end
    endtask

    task automatic test_full_fifo();
        logic [7:0] exp_ops [4];
        exp_ops = '{8'h24, 8'h25, 8'h27, 8'h28};
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_opcode = 8'h21 + 8'(i);
            in_data   = 16'h0000;
            tick();
            checks++; if (in_ready !== (i < 4)) begin failures++; $display("FAIL full_ready_%0d got=%b exp=%b", i, in_ready, (i < 4)); end
        end
        in_opcode = 8'h26;
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || opcode !== 8'h21) begin failures++; $display("FAIL full_reject ready=%b opcode=%h exp=0/21", in_ready, opcode); end
        done_pulse();
        checks++; if (opcode !== 8'h00 || in_ready !== 1'b0) begin failures++; $display("FAIL full_gap opcode=%h ready=%b exp=00/0", opcode, in_ready); end
        tick();
        checks++; if (opcode !== 8'h22 || in_ready !== 1'b1) begin failures++; $display("FAIL full_pop opcode=%h ready=%b exp=22/1", opcode, in_ready); end
        tick();
        done_pulse();
        push_one(8'h27, 16'h0000);
        checks++; if (opcode !== 8'h23 || in_ready !== 1'b1) begin failures++; $display("FAIL pushpop opcode=%h ready=%b exp=23/1", opcode, in_ready); end
        push_one(8'h28, 16'h0000);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL pushpop_count ready=%b exp=0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            done_pulse();
            tick();
            checks++; if (opcode !== exp_ops[i]) begin failures++; $display("FAIL order_%0d got=%h exp=%h", i, opcode, exp_ops[i]); end
            tick();
        end
        done_pulse();
        tick();
        checks++; if (busy !== 1'b0 || opcode !== 8'h00) begin failures++; $display("FAIL full_drain busy=%b opcode=%h exp=0/00", busy, opcode); end
    endtask

    task automatic test_reset_mid_wait();
        push_one(8'hE1, 16'h1234);
        push_one(8'h31, 16'h0000);
        tick();
        checks++; if (DataBus !== 16'h1234) begin failures++; $display("FAIL rstmid_pre_bus got=%h exp=1234", DataBus); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (opcode !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1 || !bus_released()) begin
            failures++; $display("FAIL rstmid opcode=%h busy=%b ready=%b bus=%h exp=00/0/1/released", opcode, busy, in_ready, DataBus);
        end
        tick();
        checks++; if (opcode !== 8'h00 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_empty opcode=%h busy=%b exp=00/0", opcode, busy); end
    endtask

    task automatic test_watchdog();
        push_one(8'h41, 16'h0000);
        push_one(8'h42, 16'h0000);
        tick();
        repeat (63) tick();
        checks++; if (opcode !== 8'h41 || timeout_err !== 1'b0) begin failures++; $display("FAIL wd_before opcode=%h to=%b exp=41/0", opcode, timeout_err); end
`ifdef FPP_ISSUE_TIMEOUT_EN
        tick();
        checks++; if (opcode !== 8'h00 || timeout_err !== 1'b1) begin failures++; $display("FAIL wd_fire opcode=%h to=%b exp=00/1", opcode, timeout_err); end
        tick();
        checks++; if (opcode !== 8'h42 || timeout_err !== 1'b1) begin failures++; $display("FAIL wd_next opcode=%h to=%b exp=42/1", opcode, timeout_err); end
        tick();
        done_pulse();
        tick();
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin failures++; $display("FAIL wd_sticky busy=%b to=%b exp=0/1", busy, timeout_err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL wd_clear got=%b exp=0", timeout_err); end
`else
        repeat (10) tick();
        checks++; if (opcode !== 8'h41 || timeout_err !== 1'b0) begin failures++; $display("FAIL nowd_hold opcode=%h to=%b exp=41/0", opcode, timeout_err); end
        done_pulse();
        tick();
        checks++; if (opcode !== 8'h42) begin failures++; $display("FAIL nowd_next got=%h exp=42", opcode); end
        tick();
        done_pulse();
        tick();
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL nowd_idle busy=%b to=%b exp=0/0", busy, timeout_err); end
`endif
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_opcode = 8'h00;
        in_data   = 16'h0000;
        flag      = 1'b0;
        fpp_done  = 1'b0;
        tb_drive  = 1'b0;
        tb_bus    = 16'h0000;
        @(negedge clk);
        test_reset();
        test_single_alu();
        test_load_readback();
        test_readback_idle();
        test_full_fifo();
        test_reset_mid_wait();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
